// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Optional JAL prediction is enabled by defining FETCH_JAL_PREDICT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    localparam logic [6:0]  OPC_JAL     = 7'b1101111;
    localparam logic [31:0] HALT_WORD   = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_ctrl_jal_predecode.sv
// Combinational JAL detector producing the sign-extended J-type immediate.
// Instantiated by fetch_ctrl only when FETCH_JAL_PREDICT_EN is defined.
module jal_predecode
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_jal,
    output logic [31:0] imm
);

    logic unused_rd;

    assign is_jal    = (instr[6:0] == OPC_JAL);
    assign imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    // Destination register does not affect the predicted target.
    assign unused_rd = ^instr[11:7];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, fills the IF/ID slot, applies EX redirects.
// Define FETCH_JAL_PREDICT_EN to follow JAL targets at fetch time.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_pred_taken,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  pc_step;
    logic         capture;
    logic         zero_word;
    logic         unused_redirect_bits;

`ifdef FETCH_JAL_PREDICT_EN
    logic         is_jal;
    logic [31:0]  jal_imm;

    jal_predecode u_jal_predecode (
        .instr  (imem_rdata),
        .is_jal (is_jal),
        .imm    (jal_imm)
    );

    assign pc_step = is_jal ? jal_imm : INSTR_BYTES;
`else
    assign pc_step = INSTR_BYTES;
`endif

    assign imem_addr            = pc_q;
    assign zero_word            = (imem_rdata == HALT_WORD);
    assign unused_redirect_bits = ^redirect_pc[1:0];
    // A slot is filled only when decode has room and no redirect is pending.
    assign capture = (state == RUN) && fetch_en && (!id_valid || id_ready) && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            id_valid <= 1'b0;
            id_pc    <= 32'h0;
            id_instr <= 32'h0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
            pc_q     <= {redirect_pc[31:2], 2'b00};
            halted   <= 1'b0;
            state    <= fetch_en ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: if (fetch_en) state <= RUN;
                RUN: begin
                    if (capture && zero_word) state <= HALT;
                    else if (!fetch_en)       state <= IDLE;
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase

            if (capture) begin
                if (zero_word) begin
                    id_valid <= 1'b0;
                    halted   <= 1'b1;
                end else begin
                    id_pc    <= pc_q;
                    id_instr <= imem_rdata;
                    id_valid <= 1'b1;
                    pc_q     <= pc_q + pc_step;
                end
            end else if (id_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_JAL_PREDICT_EN
    // Tracks whether the slot's successor PC came from a JAL prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            id_pred_taken <= 1'b0;
        else if (capture && !zero_word)
            id_pred_taken <= is_jal;
    end
`else
    assign id_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle reference model plus directed literal checks.
// Follows FETCH_JAL_PREDICT_EN in its model and JAL expectations.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    logic [31:0] rom [0:63];
    int          checks;
    int          errors;
    logic [31:0] acc_pc [$];
    logic [31:0] acc_instr [$];

`ifdef FETCH_JAL_PREDICT_EN
    localparam bit PREDICT = 1'b1;
`else
    localparam bit PREDICT = 1'b0;
`endif

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_pred_taken  (id_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a >= 32'hFFFF_FF00) return 32'h0000_0013;
        if (a < 32'd256)        return rom[a[7:2]];
        return 32'h0;
    endfunction

    assign imem_rdata = (imem_addr >= 32'hFFFF_FF00) ? 32'h0000_0013 :
                        (imem_addr < 32'd256) ? rom[imem_addr[7:2]] : 32'h0;

    function automatic logic [31:0] jal_offset(input logic [31:0] w);
        logic signed [20:0] off;
        off = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return {{11{off[20]}}, off};
    endfunction

    // Reference model: fetch mode flags, next PC and the slot contents.
    logic        m_running;
    logic        m_halted;
    logic        m_valid;
    logic        m_pred;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] w;
        logic        take;
        logic        jal;
        if (!rst_n) begin
            m_running  = 1'b0;
            m_halted   = 1'b0;
            m_valid    = 1'b0;
            m_pred     = 1'b0;
            m_pc       = 32'h0;
            m_id_pc    = 32'h0;
            m_id_instr = 32'h0;
        end else begin
            w    = rom_word(m_pc);
            jal  = PREDICT && (w[6:0] == 7'b1101111);
            take = m_running && fetch_en && (!m_valid || id_ready) && !redirect_valid;
            if (redirect_valid) begin
                m_valid   = 1'b0;
                m_pc      = redirect_pc & 32'hFFFF_FFFC;
                m_halted  = 1'b0;
                m_running = fetch_en;
            end else if (take && w == 32'h0) begin
                m_valid   = 1'b0;
                m_halted  = 1'b1;
                m_running = 1'b0;
            end else if (take) begin
                m_id_pc    = m_pc;
                m_id_instr = w;
                m_valid    = 1'b1;
                m_pred     = jal;
                m_pc       = m_pc + (jal ? jal_offset(w) : 32'd4);
            end else begin
                if (id_ready)  m_valid   = 1'b0;
                if (!m_halted) m_running = fetch_en;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cyc_imem_addr", imem_addr, m_pc);
            checkOutput("cyc_id_valid", {31'h0, id_valid}, {31'h0, m_valid});
            checkOutput("cyc_halted", {31'h0, halted}, {31'h0, m_halted});
            checkOutput("cyc_pred", {31'h0, id_pred_taken}, {31'h0, m_pred});
            checkOutput("cyc_id_pc", id_pc, m_id_pc);
            checkOutput("cyc_id_instr", id_instr, m_id_instr);
            if (id_valid && id_ready) begin
                acc_pc.push_back(id_pc);
                acc_instr.push_back(id_instr);
            end
        end
    end

    task automatic applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        #1;
        fetch_en       = fe;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic waitSlot(input logic [31:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            nextCycle();
            if (id_valid && id_pc == pc) found = 1'b1;
        end
        checkOutput("wait_slot", {31'h0, found}, 32'h1);
    endtask

    initial begin
        bit done;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0]  = 32'h00a00513;  rom[1]  = 32'h00a02023;
        rom[2]  = 32'h01400513;  rom[3]  = 32'h00b50533;
        rom[4]  = 32'h00a02223;  rom[5]  = 32'h00150513;
        rom[6]  = 32'hfea12fa3;  rom[7]  = 32'h00c58633;
        rom[8]  = 32'h40b50533;  rom[9]  = 32'h00d02423;
        rom[10] = 32'h7ea12fa3;
        rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        #7;
        checkOutput("reset_addr", imem_addr, 32'h0);
        checkOutput("reset_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("reset_halted", {31'h0, halted}, 32'h0);
        checkOutput("reset_id_pc", id_pc, 32'h0);
        checkOutput("reset_id_instr", id_instr, 32'h0);
        checkOutput("reset_pred", {31'h0, id_pred_taken}, 32'h0);
        nextCycle();
        #1 rst_n = 1'b1;

        // Straight-line program runs to the zero word at 44.
        applyStimulus(1, 1, 0, 0);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            nextCycle();
            if (halted) done = 1'b1;
        end
        checkOutput("halt_reached", {31'h0, done}, 32'h1);
        nextCycle();
        nextCycle();
        checkOutput("prog_count", acc_pc.size(), 32'd11);
        if (acc_pc.size() >= 11) begin
            checkOutput("prog0_pc", acc_pc[0], 32'd0);
            checkOutput("prog0_instr", acc_instr[0], 32'h00a00513);
            checkOutput("prog1_instr", acc_instr[1], 32'h00a02023);
            checkOutput("prog2_instr", acc_instr[2], 32'h01400513);
            checkOutput("prog10_pc", acc_pc[10], 32'd40);
            checkOutput("prog10_instr", acc_instr[10], 32'h7ea12fa3);
        end
        checkOutput("halt_addr", imem_addr, 32'd44);
        checkOutput("halt_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("halt_flag", {31'h0, halted}, 32'h1);

        // Redirect out of HALT restarts fetch at 0.
        applyStimulus(1, 1, 1, 32'h0);
        nextCycle();
        checkOutput("unhalt_flag", {31'h0, halted}, 32'h0);
        checkOutput("unhalt_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("unhalt_addr", imem_addr, 32'h0);
        applyStimulus(1, 1, 0, 0);
        nextCycle();
        checkOutput("restart_pc", id_pc, 32'h0);

        // Stall on slot 8 for three cycles.
        waitSlot(32'd8);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("stall_pc", id_pc, 32'd8);
            checkOutput("stall_instr", id_instr, 32'h01400513);
            checkOutput("stall_addr", imem_addr, 32'd12);
        end
        applyStimulus(1, 1, 0, 0);
        nextCycle();
        checkOutput("release_pc", id_pc, 32'd12);

        // Redirect to 0x1B while slot 16 is shown.
        waitSlot(32'd16);
        applyStimulus(1, 1, 1, 32'h0000_001B);
        nextCycle();
        checkOutput("redir_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("redir_addr", imem_addr, 32'h18);
        applyStimulus(1, 1, 0, 0);
        nextCycle();
        checkOutput("redir_tgt_pc", id_pc, 32'h18);
        checkOutput("redir_tgt_instr", id_instr, 32'hfea12fa3);

        // Redirect during a stall still flushes the slot.
        waitSlot(32'd28);
        applyStimulus(1, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 0, 1, 32'h4);
        nextCycle();
        checkOutput("stallredir_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("stallredir_addr", imem_addr, 32'h4);
        applyStimulus(1, 1, 0, 0);
        nextCycle();
        checkOutput("stallredir_pc", id_pc, 32'h4);
        checkOutput("stallredir_instr", id_instr, 32'h00a02023);

        // PC increment wraps from the top of the address space.
        applyStimulus(1, 1, 1, 32'hFFFF_FFFC);
        nextCycle();
        applyStimulus(1, 1, 0, 0);
        nextCycle();
        checkOutput("wrap_pc", id_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset mid-run, then an IDLE-only redirect.
        waitSlot(32'd20);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("async_addr", imem_addr, 32'h0);
        checkOutput("async_id_pc", id_pc, 32'h0);
        fetch_en = 1'b0;
        nextCycle();
        #1 rst_n = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("idle_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("idle_addr", imem_addr, 32'h0);
        applyStimulus(0, 1, 1, 32'h20);
        nextCycle();
        applyStimulus(0, 1, 0, 0);
        nextCycle();
        checkOutput("idle_redir_addr", imem_addr, 32'h20);
        checkOutput("idle_redir_valid", {31'h0, id_valid}, 32'h0);
        applyStimulus(1, 1, 0, 0);
        nextCycle();
        nextCycle();
        checkOutput("idle_resume_pc", id_pc, 32'h20);
        checkOutput("idle_resume_instr", id_instr, 32'h40b50533);

        // JAL at PC 0: predicted target when enabled, plain +4 otherwise.
        applyStimulus(0, 0, 0, 0);
        rom[0] = 32'h0080006f;
        #1 rst_n = 1'b0;
        nextCycle();
        #1 rst_n = 1'b1;
        applyStimulus(1, 1, 0, 0);
        nextCycle();
        nextCycle();
        checkOutput("jal_pc", id_pc, 32'h0);
        checkOutput("jal_pred", {31'h0, id_pred_taken}, {31'h0, PREDICT});
        nextCycle();
        checkOutput("jal_next_pc", id_pc, PREDICT ? 32'd8 : 32'd4);
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
